vec_lane_sequencer: RTL and testbench

//  Multi-lane vector ALU sequencer. Executes one RVV integer vector-vector, vector-scalar or

---
 rtl/vec_pkg.sv | 52 +++++
 rtl/vec_lane_op.sv | 53 +++++
 rtl/vec_lane_sequencer.sv | 171 +++++++++++++++++
 tb/tb_vec_lane_sequencer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_pkg.sv
// Shared encodings for the vector lane sequencer: SEW codes, funct6 values,
// operand-type one-hot codes, FSM state type and small legality helpers.
package vec_pkg;

  localparam logic [2:0] SEW_8  = 3'd0;
  localparam logic [2:0] SEW_16 = 3'd1;
  localparam logic [2:0] SEW_32 = 3'd2;
  localparam logic [2:0] SEW_64 = 3'd3;

  localparam logic [2:0] OPT_VV = 3'b001;
  localparam logic [2:0] OPT_VX = 3'b010;
  localparam logic [2:0] OPT_VI = 3'b100;

  localparam logic [5:0] F6_VADD  = 6'b000000;
  localparam logic [5:0] F6_VSUB  = 6'b000010;
  localparam logic [5:0] F6_VMINU = 6'b000100;
  localparam logic [5:0] F6_VMIN  = 6'b000101;
  localparam logic [5:0] F6_VMAXU = 6'b000110;
  localparam logic [5:0] F6_VMAX  = 6'b000111;
  localparam logic [5:0] F6_VAND  = 6'b001001;
  localparam logic [5:0] F6_VOR   = 6'b001010;
  localparam logic [5:0] F6_VXOR  = 6'b001011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } seq_state_t;

  function automatic int unsigned sew_bits(input logic [2:0] vsew);
    return 32'd8 << vsew;
  endfunction

  function automatic int unsigned vlmax(input int unsigned vlen, input logic [2:0] vsew);
    return vlen >> (32'(vsew) + 32'd3);
  endfunction

  function automatic logic sew_legal(input logic [2:0] vsew, input int unsigned elen);
    return (vsew <= SEW_64) && (sew_bits(vsew) <= elen);
  endfunction

  function automatic logic op_type_legal(input logic [2:0] op_type);
    return (op_type == OPT_VV) || (op_type == OPT_VX) || (op_type == OPT_VI);
  endfunction

  function automatic logic opcode_legal(input logic [5:0] f6);
    return (f6 == F6_VADD) || (f6 == F6_VSUB) || (f6 == F6_VMINU) ||
           (f6 == F6_VMIN) || (f6 == F6_VMAXU) || (f6 == F6_VMAX) ||
           (f6 == F6_VAND) || (f6 == F6_VOR) || (f6 == F6_VXOR);
  endfunction

endpackage

// File: rtl/vec_lane_op.sv
// One ALU lane: ELEN-wide datapath that operates modulo 2^SEW. Result bits
// above SEW are always zero so the sequencer can merge it with a plain shift.
module vec_lane_op
  import vec_pkg::*;
#(
  parameter int ELEN = 64
) (
  input  logic [5:0]      opcode,
  input  logic [2:0]      vsew,
  input  logic [ELEN-1:0] a,
  input  logic [ELEN-1:0] b,
  output logic [ELEN-1:0] result,
  output logic            illegal
);

  logic            sew_ok;
  logic [ELEN-1:0] mask;
  logic [ELEN-1:0] sign_bit;
  logic [ELEN-1:0] a_m;
  logic [ELEN-1:0] b_m;
  logic [ELEN-1:0] a_x;
  logic [ELEN-1:0] b_x;
  logic            lt_u;
  logic            lt_s;

  always_comb begin
    sew_ok   = sew_legal(vsew, ELEN);
    mask     = sew_ok ? ({ELEN{1'b1}} >> (ELEN - sew_bits(vsew))) : '0;
    sign_bit = mask ^ (mask >> 1);
    a_m      = a & mask;
    b_m      = b & mask;
    // Sign-extend from SEW so a full-width signed compare gives the SEW answer.
    a_x      = ((a_m & sign_bit) != '0) ? (a_m | ~mask) : a_m;
    b_x      = ((b_m & sign_bit) != '0) ? (b_m | ~mask) : b_m;
    lt_u     = a_m < b_m;
    lt_s     = $signed(a_x) < $signed(b_x);
    illegal  = !sew_ok || !opcode_legal(opcode);
    result   = '0;
    case (opcode)
      F6_VADD:  result = (a_m + b_m) & mask;
      F6_VSUB:  result = (a_m - b_m) & mask;
      F6_VAND:  result = a_m & b_m;
      F6_VOR:   result = a_m | b_m;
      F6_VXOR:  result = a_m ^ b_m;
      F6_VMINU: result = lt_u ? a_m : b_m;
      F6_VMIN:  result = lt_s ? a_m : b_m;
      F6_VMAXU: result = lt_u ? b_m : a_m;
      F6_VMAX:  result = lt_s ? b_m : a_m;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/vec_lane_sequencer.sv
// Vector ALU sequencer: latches one RVV integer op, walks vl elements LANES
// at a time through vec_lane_op instances, merging under v0 mask into vd.
module vec_lane_sequencer
  import vec_pkg::*;
#(
  parameter int VLEN  = 128,
  parameter int LANES = 4,
  parameter int ELEN  = 64,
  localparam int VL_W = $clog2(VLEN) + 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [5:0]        opcode,
  input  logic [2:0]        op_type,
  input  logic [2:0]        vsew,
  input  logic [VL_W-1:0]   vl,
  input  logic              vm,
  input  logic [VLEN-1:0]   v0,
  input  logic [VLEN-1:0]   vs1,
  input  logic [VLEN-1:0]   vs2,
  input  logic [ELEN-1:0]   scalar,
  input  logic [VLEN-1:0]   vd_old,
  output logic [VLEN-1:0]   vd,
  output logic              busy,
  output logic              done,
  output logic              err,
  output seq_state_t        state
);

  localparam int IDX_W = VL_W + 1;
  localparam int OFF_W = IDX_W + 7;

  // Handshake: start is sampled only while idle; busy is high from the cycle
  // after an accepted start until the cycle after done; done is a single-cycle
  // pulse and vd/err are valid while it is high (vd then holds until next start).

  logic [5:0]       opcode_q;
  logic [2:0]       op_type_q;
  logic [2:0]       vsew_q;
  logic             vm_q;
  logic [VLEN-1:0]  v0_q;
  logic [VLEN-1:0]  vs1_q;
  logic [VLEN-1:0]  vs2_q;
  logic [ELEN-1:0]  scalar_q;
  logic [VL_W-1:0]  vl_eff;
  logic [IDX_W-1:0] elem_i;

  logic [IDX_W-1:0] lane_idx [LANES];
  logic [OFF_W-1:0] lane_off [LANES];
  logic [ELEN-1:0]  lane_a   [LANES];
  logic [ELEN-1:0]  lane_b   [LANES];
  logic [ELEN-1:0]  lane_res [LANES];
  logic [LANES-1:0] lane_en;
  logic [LANES-1:0] lane_ill;
  logic [ELEN-1:0]  sew_mask;
  logic [VLEN-1:0]  vd_next;
  int unsigned      vl_cap;
  logic [VL_W-1:0]  vl_clip;
  logic             launch_bad;

  always_comb begin
    vl_cap     = vlmax(VLEN, vsew);
    vl_clip    = (32'(vl) > vl_cap) ? VL_W'(vl_cap) : vl;
    launch_bad = !sew_legal(vsew, ELEN) || !op_type_legal(op_type);
  end

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_idx[l] = elem_i + IDX_W'(l);
      lane_off[l] = OFF_W'(lane_idx[l]) << (32'(vsew_q) + 32'd3);
      lane_a[l]   = ELEN'(vs2_q >> lane_off[l]);
      case (op_type_q)
        OPT_VV:  lane_b[l] = ELEN'(vs1_q >> lane_off[l]);
        OPT_VX:  lane_b[l] = scalar_q;
        default: lane_b[l] = {{(ELEN-5){scalar_q[4]}}, scalar_q[4:0]};
      endcase
      lane_en[l] = (lane_idx[l] < IDX_W'(vl_eff)) &&
                   (vm_q || |(v0_q & (VLEN'(1) << lane_idx[l])));
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    vec_lane_op #(.ELEN(ELEN)) u_op (
      .opcode  (opcode_q),
      .vsew    (vsew_q),
      .a       (lane_a[l]),
      .b       (lane_b[l]),
      .result  (lane_res[l]),
      .illegal (lane_ill[l])
    );
  end

  // Lanes touch disjoint elements, so merging them one after another is order-free.
  always_comb begin
    sew_mask = {ELEN{1'b1}} >> (ELEN - sew_bits(vsew_q));
    vd_next  = vd;
    for (int l = 0; l < LANES; l++) begin
      if (lane_en[l] && !lane_ill[l]) begin
        vd_next = (vd_next & ~(VLEN'(sew_mask) << lane_off[l])) |
                  (VLEN'(lane_res[l]) << lane_off[l]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= S_IDLE;
      vd        <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      opcode_q  <= '0;
      op_type_q <= '0;
      vsew_q    <= '0;
      vm_q      <= 1'b0;
      v0_q      <= '0;
      vs1_q     <= '0;
      vs2_q     <= '0;
      scalar_q  <= '0;
      vl_eff    <= '0;
      elem_i    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            opcode_q  <= opcode;
            op_type_q <= op_type;
            vsew_q    <= vsew;
            vm_q      <= vm;
            v0_q      <= v0;
            vs1_q     <= vs1;
            vs2_q     <= vs2;
            scalar_q  <= scalar;
            vl_eff    <= vl_clip;
            elem_i    <= '0;
            vd        <= vd_old;
            busy      <= 1'b1;
            if (launch_bad) begin
              state <= S_DONE;
              err   <= 1'b1;
              done  <= 1'b1;
            end else begin
              state <= S_RUN;
              err   <= 1'b0;
            end
          end
        end
        S_RUN: begin
          vd     <= vd_next;
          elem_i <= elem_i + IDX_W'(LANES);
          if (|lane_ill) err <= 1'b1;
          if (elem_i + IDX_W'(LANES) >= IDX_W'(vl_eff)) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vec_lane_sequencer.sv
// Randomised and directed checks of vec_lane_sequencer against an
// element-by-element reference model of the vector ALU semantics.
module tb_vec_lane_sequencer;
  import vec_pkg::*;

  localparam int VLEN  = 128;
  localparam int LANES = 4;
  localparam int ELEN  = 64;
  localparam int VL_W  = 8;

  logic             clk;
  logic             resetn;
  logic             start;
  logic [5:0]       opcode;
  logic [2:0]       op_type;
  logic [2:0]       vsew;
  logic [VL_W-1:0]  vl;
  logic             vm;
  logic [VLEN-1:0]  v0;
  logic [VLEN-1:0]  vs1;
  logic [VLEN-1:0]  vs2;
  logic [ELEN-1:0]  scalar;
  logic [VLEN-1:0]  vd_old;
  logic [VLEN-1:0]  vd;
  logic             busy;
  logic             done;
  logic             err;
  seq_state_t       dut_state;

  int n_checks = 0;
  int n_pass   = 0;
  logic [VLEN-1:0] exp_q[$];

  vec_lane_sequencer #(.VLEN(VLEN), .LANES(LANES), .ELEN(ELEN)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .start   (start),
    .opcode  (opcode),
    .op_type (op_type),
    .vsew    (vsew),
    .vl      (vl),
    .vm      (vm),
    .v0      (v0),
    .vs1     (vs1),
    .vs2     (vs2),
    .scalar  (scalar),
    .vd_old  (vd_old),
    .vd      (vd),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .state   (dut_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [VLEN-1:0] got,
                           input logic [VLEN-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Reference model: walks elements with plain arithmetic at the given SEW.
  function automatic void model(input logic [5:0] f6, input logic [2:0] typ,
                                input logic [2:0] sew_c, input logic [7:0] vl_i,
                                input logic vm_i, input logic [127:0] v0_i,
                                input logic [127:0] vs1_i, input logic [127:0] vs2_i,
                                input logic [63:0] sc, input logic [127:0] vdo,
                                output logic [127:0] r, output logic e, output int lat);
    int sew, vmax, vle;
    logic [63:0] m, half, a, b, y, imm;
    r = vdo;
    e = 1'b0;
    lat = -1;
    if (sew_c > 3'd3 || !(typ == 3'b001 || typ == 3'b010 || typ == 3'b100)) begin
      e = 1'b1;
      return;
    end
    sew  = 8 << sew_c;
    vmax = 128 / sew;
    vle  = (int'(vl_i) < vmax) ? int'(vl_i) : vmax;
    lat  = (vle == 0) ? 2 : (vle + LANES - 1) / LANES + 1;
    if (!(f6 inside {6'h00, 6'h02, 6'h04, 6'h05, 6'h06, 6'h07, 6'h09, 6'h0A, 6'h0B})) begin
      e = 1'b1;
      return;
    end
    m    = (sew == 64) ? '1 : ((64'd1 << sew) - 64'd1);
    half = 64'd1 << (sew - 1);
    imm  = {{59{sc[4]}}, sc[4:0]};
    for (int j = 0; j < vle; j++) begin
      if (vm_i || v0_i[j]) begin
        a = 64'(vs2_i >> (j * sew)) & m;
        if (typ == 3'b001)      b = 64'(vs1_i >> (j * sew)) & m;
        else if (typ == 3'b010) b = sc & m;
        else                    b = imm & m;
        case (f6)
          6'h00:   y = (a + b) & m;
          6'h02:   y = (a - b) & m;
          6'h09:   y = a & b;
          6'h0A:   y = a | b;
          6'h0B:   y = a ^ b;
          6'h04:   y = (a < b) ? a : b;
          6'h06:   y = (a > b) ? a : b;
          6'h05:   y = ((a ^ half) < (b ^ half)) ? a : b;
          default: y = ((a ^ half) > (b ^ half)) ? a : b;
        endcase
        r = (r & ~(128'(m) << (j * sew))) | (128'(y) << (j * sew));
      end
    end
  endfunction

  // driver: launch one op, scramble inputs during RUN, wait for done and score
  task automatic run_op(input string tag, input logic [5:0] f6, input logic [2:0] typ,
                        input logic [2:0] sew_c, input logic [7:0] vl_i, input logic vm_i,
                        input logic [127:0] v0_i, input logic [127:0] vs1_i,
                        input logic [127:0] vs2_i, input logic [63:0] sc,
                        input logic [127:0] vdo, input bit dup_start,
                        output logic [127:0] got);
    logic [127:0] exp_vd;
    logic exp_err;
    int lat, cycles;
    @(negedge clk);
    opcode = f6; op_type = typ; vsew = sew_c; vl = vl_i; vm = vm_i;
    v0 = v0_i; vs1 = vs1_i; vs2 = vs2_i; scalar = sc; vd_old = vdo;
    start = 1'b1;
    model(f6, typ, sew_c, vl_i, vm_i, v0_i, vs1_i, vs2_i, sc, vdo, exp_vd, exp_err, lat);
    exp_q.push_back(exp_vd);
    @(posedge clk);
    #1;
    start = 1'b0;
    opcode = 6'($urandom()); op_type = 3'($urandom()); vsew = 3'($urandom());
    vl = 8'($urandom()); vm = 1'($urandom());
    v0 = rand128(); vs1 = rand128(); vs2 = rand128(); vd_old = rand128();
    scalar = {$urandom(), $urandom()};
    cycles = 1;
    while (!done && cycles < 64) begin
      start = dup_start && (cycles == 2);
      @(posedge clk);
      #1;
      cycles++;
    end
    start = 1'b0;
    got = vd;
    check_val({tag, ".done"}, 128'(done), 128'(1));
    check_val({tag, ".vd"}, vd, exp_q.pop_front());
    check_val({tag, ".err"}, 128'(err), 128'(exp_err));
    if (lat > 0) check_val({tag, ".lat"}, 128'(cycles), 128'(lat));
    @(posedge clk);
    #1;
    check_val({tag, ".idle"}, {126'd0, busy, done}, 128'd0);
    check_val({tag, ".hold"}, vd, got);
  endtask

  initial begin
    logic [127:0] got, bytes_i;
    logic [5:0] ops [9] = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h06, 6'h07, 6'h09, 6'h0A, 6'h0B};
    logic [2:0] typs [3] = '{3'b001, 3'b010, 3'b100};
    logic [5:0] f6;
    logic [2:0] typ, sew_c;

    resetn = 1'b0; start = 1'b0; opcode = '0; op_type = '0; vsew = '0; vl = '0;
    vm = 1'b0; v0 = '0; vs1 = '0; vs2 = '0; scalar = '0; vd_old = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset", {vd, busy, done, err}, '0);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 16; i++) bytes_i[i*8 +: 8] = 8'(i);
    run_op("t1_vadd_vv", F6_VADD, OPT_VV, SEW_8, 8'd16, 1'b1, '0, bytes_i,
           {16{8'h10}}, 64'd0, rand128(), 1'b0, got);
    check_val("t1_const", got, 128'h1F1E1D1C1B1A19181716151413121110);

    run_op("t2_vsub_vx", F6_VSUB, OPT_VX, SEW_32, 8'd3, 1'b1, '0, '0,
           {4{32'd5}}, 64'd1, {4{32'hAAAAAAAA}}, 1'b0, got);
    check_val("t2_const", got, {32'hAAAAAAAA, {3{32'd4}}});

    run_op("t3_vadd_vi", F6_VADD, OPT_VI, SEW_16, 8'd8, 1'b0, 128'h55, '0,
           {8{16'h0005}}, 64'h1F, {8{16'hBEEF}}, 1'b0, got);
    check_val("t3_const", got, {4{16'hBEEF, 16'h0004}});

    run_op("t4_vmin", F6_VMIN, OPT_VV, SEW_64, 8'd2, 1'b1, '0,
           {64'd5, 64'hFFFF_FFFF_FFFF_FFFF}, {64'd3, 64'd3}, 64'd0, rand128(), 1'b0, got);
    check_val("t4_const", got, {64'd3, 64'hFFFF_FFFF_FFFF_FFFF});
    run_op("t4_vminu", F6_VMINU, OPT_VV, SEW_64, 8'd2, 1'b1, '0,
           {64'd5, 64'hFFFF_FFFF_FFFF_FFFF}, {64'd3, 64'd3}, 64'd0, rand128(), 1'b0, got);
    check_val("t4u_const", got, {64'd3, 64'd3});

    run_op("t5_clip", F6_VADD, OPT_VV, SEW_8, 8'd200, 1'b1, '0, rand128(), rand128(),
           64'd0, rand128(), 1'b0, got);
    run_op("t5_vl0", F6_VXOR, OPT_VV, SEW_8, 8'd0, 1'b1, '0, rand128(), rand128(),
           64'd0, 128'h0123456789ABCDEF_FEDCBA9876543210, 1'b0, got);
    run_op("t5_badsew", F6_VADD, OPT_VV, 3'd4, 8'd4, 1'b1, '0, rand128(), rand128(),
           64'd0, rand128(), 1'b0, got);
    run_op("t5_badtype", F6_VADD, 3'b011, SEW_8, 8'd4, 1'b1, '0, rand128(), rand128(),
           64'd0, rand128(), 1'b0, got);
    run_op("t5_badop", 6'h3F, OPT_VV, SEW_16, 8'd8, 1'b1, '0, rand128(), rand128(),
           64'd0, rand128(), 1'b0, got);

    run_op("t6_dup", F6_VADD, OPT_VV, SEW_8, 8'd16, 1'b1, '0, bytes_i,
           {16{8'h10}}, 64'd0, rand128(), 1'b1, got);

    for (int k = 0; k < 60; k++) begin
      f6    = ($urandom_range(0, 9) == 0) ? 6'($urandom()) : ops[$urandom_range(0, 8)];
      typ   = ($urandom_range(0, 15) == 0) ? 3'($urandom()) : typs[$urandom_range(0, 2)];
      sew_c = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      run_op($sformatf("rnd%0d", k), f6, typ, sew_c, 8'($urandom_range(0, 20)),
             1'($urandom()), rand128(), rand128(), rand128(),
             {$urandom(), $urandom()}, rand128(), 1'($urandom()), got);
    end

    // reset in the middle of RUN aborts without a done pulse
    @(negedge clk);
    opcode = F6_VADD; op_type = OPT_VV; vsew = SEW_8; vl = 8'd16; vm = 1'b1;
    vs1 = rand128(); vs2 = rand128(); vd_old = rand128();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check_val("rst_mid.busy_before", 128'(busy), 128'(1));
    resetn = 1'b0;
    @(posedge clk);
    #1;
    check_val("rst_mid", {vd, busy, done, err}, '0);
    repeat (3) begin
      @(posedge clk);
      #1;
      check_val("rst_mid.nodone", 128'(done), 128'(0));
    end
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_mid.idle", {126'd0, busy, done}, 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
